// File: rtl/keypad_emu.sv
// ============================================================================
//  Module   : keypad_emu
//  Purpose  : Emulates one key of a 4x4 scanned keypad: latches a hex code,
//             holds it for HOLD_CYCLES, then releases it for GAP_CYCLES.
//             Define KEYPAD_BOUNCE_EN to add contact bounce at press/release.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_emu #(
  parameter logic [31:0] HOLD_CYCLES   = 32'd1000000,
  parameter logic [31:0] GAP_CYCLES    = 32'd250000,
  parameter logic [31:0] BOUNCE_CYCLES = 32'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypadRow,
  output logic [3:0] keypadCol,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       cancel,
  output logic       busy,
  output logic       press_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic        press_done_q, press_done_d;
  logic [3:0]  tgt_row, tgt_col;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    press_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          code_d  = key_code;
          cnt_d   = 32'd0;
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        // cancel wins over a completion on the same edge, so no pulse
        if (cancel) begin
          cnt_d   = 32'd0;
          state_d = S_GAP;
        end else if (cnt_q == HOLD_CYCLES - 32'd1) begin
          cnt_d        = 32'd0;
          state_d      = S_GAP;
          press_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_CYCLES - 32'd1) begin
          cnt_d   = 32'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        cnt_d   = 32'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      code_q       <= 4'd0;
      press_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      press_done_q <= press_done_d;
    end
  end

  always_comb begin
    tgt_row = 4'b1110;
    tgt_col = 4'b1110;
    case (code_q)
      4'h0: begin tgt_row = 4'b1110; tgt_col = 4'b0111; end
      4'h1: begin tgt_row = 4'b1110; tgt_col = 4'b1011; end
      4'h2: begin tgt_row = 4'b1101; tgt_col = 4'b1011; end
      4'h3: begin tgt_row = 4'b1011; tgt_col = 4'b1011; end
      4'h4: begin tgt_row = 4'b1110; tgt_col = 4'b1101; end
      4'h5: begin tgt_row = 4'b1101; tgt_col = 4'b1101; end
      4'h6: begin tgt_row = 4'b1011; tgt_col = 4'b1101; end
      4'h7: begin tgt_row = 4'b1110; tgt_col = 4'b1110; end
      4'h8: begin tgt_row = 4'b1101; tgt_col = 4'b1110; end
      4'h9: begin tgt_row = 4'b1011; tgt_col = 4'b1110; end
      4'hA: begin tgt_row = 4'b1101; tgt_col = 4'b0111; end
      4'hB: begin tgt_row = 4'b1011; tgt_col = 4'b0111; end
      4'hC: begin tgt_row = 4'b0111; tgt_col = 4'b1110; end
      4'hD: begin tgt_row = 4'b0111; tgt_col = 4'b1101; end
      4'hE: begin tgt_row = 4'b0111; tgt_col = 4'b1011; end
      default: begin tgt_row = 4'b0111; tgt_col = 4'b0111; end
    endcase
  end

`ifdef KEYPAD_BOUNCE_EN
  logic in_bounce;
  assign in_bounce = (cnt_q < BOUNCE_CYCLES);

  // Contacts chatter on even/odd counts at the start of press and release
  always_comb begin
    keypadCol = 4'b1111;
    if (keypadRow == tgt_row) begin
      if (state_q == S_PRESS && (!in_bounce || !cnt_q[0]))
        keypadCol = tgt_col;
      else if (state_q == S_GAP && in_bounce && !cnt_q[0])
        keypadCol = tgt_col;
    end
  end
`else
  logic unused_bounce_cfg;
  assign unused_bounce_cfg = ^BOUNCE_CYCLES;

  always_comb begin
    keypadCol = 4'b1111;
    if (state_q == S_PRESS && keypadRow == tgt_row)
      keypadCol = tgt_col;
  end
`endif

  assign key_ready  = (state_q == S_IDLE);
  assign busy       = ~key_ready;
  assign press_done = press_done_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emu.sv
// ============================================================================
//  Module   : tb_keypad_emu
//  Purpose  : Self-checking bench for keypad_emu: timestamp-based reference
//             model, directed scenarios and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_emu;

  localparam int HOLD   = 8;
  localparam int GAP    = 4;
  localparam int BOUNCE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keypadRow = 4'b1111;
  logic [3:0] keypadCol;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_ready;
  logic       cancel = 1'b0;
  logic       busy;
  logic       press_done;

  int n_chk  = 0;
  int n_pass = 0;

  keypad_emu #(
    .HOLD_CYCLES  (32'(HOLD)),
    .GAP_CYCLES   (32'(GAP)),
    .BOUNCE_CYCLES(32'(BOUNCE))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .keypadRow (keypadRow),
    .keypadCol (keypadCol),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .cancel    (cancel),
    .busy      (busy),
    .press_done(press_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a press is described by the cycle it starts, the cycle
  // its release starts and the cycle the emulator is ready again.
  longint cyc    = 0;
  longint acc_t  = -1;
  longint gap_t  = -1;
  longint rdy_t  = -1;
  logic   full   = 1'b0;
  logic [3:0] m_code = 4'h0;

  function automatic void tgt(input logic [3:0] code, output logic [3:0] r, output logic [3:0] c);
    logic [63:0] t;
    t = 64'h7410_852A_963B_CDEF;
    r = 4'b1110;
    c = 4'b1110;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (t[63 - 4*(ri*4 + ci) -: 4] == code) begin
          r = ~(4'b0001 << ri);
          c = ~(4'b0001 << ci);
        end
  endfunction

  function automatic logic [3:0] exp_col(input longint n, input logic [3:0] row);
    logic [3:0] r, c;
    longint k;
    tgt(m_code, r, c);
    if (row != r) return 4'b1111;
    if (n >= acc_t && n < gap_t) begin
      k = n - acc_t;
`ifdef KEYPAD_BOUNCE_EN
      if (k < BOUNCE && k[0]) return 4'b1111;
`endif
      return c;
    end
    if (n >= gap_t && n < rdy_t) begin
      k = n - gap_t;
`ifdef KEYPAD_BOUNCE_EN
      if (k < BOUNCE && !k[0]) return c;
`endif
      return 4'b1111;
    end
    return 4'b1111;
  endfunction

  always @(posedge clk or posedge reset) begin
    cyc <= cyc + 1;
    if (reset) begin
      acc_t  <= -1;
      gap_t  <= -1;
      rdy_t  <= -1;
      full   <= 1'b0;
      m_code <= 4'h0;
    end else if (!(cyc >= acc_t && cyc < rdy_t)) begin
      if (key_valid) begin
        acc_t  <= cyc + 1;
        gap_t  <= cyc + 1 + HOLD;
        rdy_t  <= cyc + 1 + HOLD + GAP;
        full   <= 1'b1;
        m_code <= key_code;
      end
    end else if (cyc < gap_t && cancel) begin
      gap_t <= cyc + 1;
      rdy_t <= cyc + 1 + GAP;
      full  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic e_rdy;
    e_rdy = !(cyc >= acc_t && cyc < rdy_t);
    check("key_ready", 32'(key_ready), 32'(e_rdy));
    check("busy", 32'(busy), 32'(!e_rdy));
    check("press_done", 32'(press_done), 32'(full && cyc == gap_t));
    check("keypadCol", 32'(keypadCol), 32'(exp_col(cyc, keypadRow)));
  end

  task automatic issue(input logic [3:0] code, input logic [3:0] row);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_code  = code;
    keypadRow = row;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  initial begin
    int on_cnt, pd_cnt, rdy_at;
    logic [3:0] r, c;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(key_ready), 32'd1);
    check("reset_col", 32'(keypadCol), 32'hF);

    // code 5 on row 1101: 8 cycles of column 1101, one pulse, ready after 12
    issue(4'h5, 4'b1101);
    on_cnt = 0; pd_cnt = 0; rdy_at = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (keypadCol == 4'b1101) on_cnt++;
      if (press_done) pd_cnt++;
      if (key_ready && rdy_at < 0) rdy_at = i;
    end
    check("hold_len", 32'(on_cnt), 32'd8);
    check("done_pulses", 32'(pd_cnt), 32'd1);
    check("ready_after", 32'(rdy_at), 32'd12);

    // cancel during the third press cycle
    issue(4'h3, 4'b1011);
    pd_cnt = 0; rdy_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) check("pre_cancel_col", 32'(keypadCol), 32'hB);
`ifdef KEYPAD_BOUNCE_EN
      if (i == 3) check("post_cancel_col", 32'(keypadCol), 32'hB);
`else
      if (i == 3) check("post_cancel_col", 32'(keypadCol), 32'hF);
`endif
      if (press_done) pd_cnt++;
      if (key_ready && rdy_at < 0) rdy_at = i;
      cancel = (i == 2);
    end
    cancel = 1'b0;
    check("cancel_no_done", 32'(pd_cnt), 32'd0);
    check("cancel_ready_after", 32'(rdy_at), 32'd7);

    // asynchronous reset in the middle of a press
    issue(4'hF, 4'b0111);
    repeat (3) @(negedge clk);
    check("midpress_col", 32'(keypadCol), 32'h7);
    #2 reset = 1'b1;
    #1;
    check("async_rst_col", 32'(keypadCol), 32'hF);
    check("async_rst_ready", 32'(key_ready), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    pd_cnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (press_done) pd_cnt++;
    end
    check("rst_no_done", 32'(pd_cnt), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      @(posedge clk); #1;
      key_valid = ($urandom % 3 == 0);
      key_code  = 4'($urandom);
      cancel    = ($urandom % 8 == 0);
      sel = int'($urandom % 8);
      tgt(m_code, r, c);
      if (sel < 4) keypadRow = ~(4'b0001 << sel);
      else if (sel == 4) keypadRow = 4'b1111;
      else if (sel < 7) keypadRow = r;
      else keypadRow = 4'($urandom);
      if ($urandom % 400 == 0) begin
        #2 reset = 1'b1;
        #1;
        check("rand_rst_col", 32'(keypadCol), 32'hF);
        check("rand_rst_ready", 32'(key_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_emu.md
KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
REQ-001 Parameter HOLD_CYCLES, default 32'd1000000, sets the key-held duration in clk cycles (minimum 1).
REQ-002 Parameter GAP_CYCLES, default 32'd250000, sets the released gap after each press in clk cycles (minimum 1).
REQ-003 Parameter BOUNCE_CYCLES, default 16, sets the bounce window length in clk cycles (1 to HOLD_CYCLES and 1 to GAP_CYCLES).
REQ-004 Port clk, input, 1 bit: sole clock, rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port keypadRow, input, 4 bits: active-low row strobe driven by the scanner.
REQ-007 Port keypadCol, output, 4 bits: active-low column lines returned to the scanner.
REQ-008 Port key_valid, input, 1 bit: request to press the key in key_code.
REQ-009 Port key_code, input, 4 bits: hex key to press.
REQ-010 Port key_ready, output, 1 bit: high when a request can be accepted.
REQ-011 Port cancel, input, 1 bit: abort the current press.
REQ-012 Port busy, output, 1 bit: high in PRESS or GAP.
REQ-013 Port press_done, output, 1 bit: one-cycle pulse when a press completes its full hold.

Function
REQ-014 The FSM SHALL have three states: IDLE, PRESS and GAP.
REQ-015 key_ready SHALL be high exactly in IDLE, and busy SHALL equal the inverse of key_ready.
REQ-016 In IDLE, key_valid=1 SHALL latch key_code, clear the 32-bit counter and enter PRESS on the next edge.
REQ-017 key_valid while busy SHALL be ignored, with no queueing.
REQ-018 The latched code SHALL map to a target row and column as follows.
  - row 1110: col 1110=7, 1101=4, 1011=1, 0111=0.
  - row 1101: col 1110=8, 1101=5, 1011=2, 0111=A.
  - row 1011: col 1110=9, 1101=6, 1011=3, 0111=B.
  - row 0111: col 1110=C, 1101=D, 1011=E, 0111=F.
REQ-019 keypadCol SHALL be combinational in keypadRow: in PRESS with keypadRow equal to the target row it SHALL equal the target column, otherwise 4'b1111.
REQ-020 A keypadRow that is not exactly the target row (including 1111 or multiple lows) SHALL give 4'b1111.
REQ-021 PRESS SHALL last exactly HOLD_CYCLES cycles, then enter GAP and assert press_done for the first GAP cycle.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE, making the accept-to-ready period HOLD_CYCLES+GAP_CYCLES cycles.
REQ-023 cancel=1 in PRESS SHALL enter GAP on the next edge with the counter cleared and no press_done.
REQ-024 cancel in IDLE or GAP SHALL be ignored.
REQ-025 key_valid and cancel asserted together in IDLE SHALL be accepted as a normal request.
REQ-026 The counter SHALL clear on every state change and SHALL never wrap within a state.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, counter=0, latched code=0 and press_done=0, giving keypadCol=1111, key_ready=1 and busy=0.
REQ-028 Reset asserted mid-PRESS or mid-GAP SHALL abort without a press_done pulse.
REQ-029 Operation SHALL resume on the first clk edge after reset deasserts.

Configuration
REQ-030 With macro KEYPAD_BOUNCE_EN defined, keypadCol SHALL bounce in the first BOUNCE_CYCLES cycles of PRESS and of GAP.
  - Bounce applies only while keypadRow equals the target row.
  - On counter[0]=0 the output SHALL be the target column; on counter[0]=1 it SHALL be 4'b1111.
  - After the bounce window, outputs SHALL be clean per REQ-019.
REQ-031 Without KEYPAD_BOUNCE_EN, no bounce logic SHALL be compiled and outputs SHALL be clean at all times.

Verification
REQ-032 Scenario: HOLD=8, GAP=4; key_code=5 for one cycle; keypadRow=1101 held.
  - keypadCol=1101 for exactly 8 cycles, then 1111.
  - press_done pulses once.
  - key_ready returns after 12 cycles.
REQ-033 Scenario: code=F; keypadRow cycles 1110→1101→1011→0111 during PRESS.
  - keypadCol=0111 only while the row is 0111, otherwise 1111.
REQ-034 Scenario: key_valid held high continuously with code=2.
  - Back-to-back presses every 12 cycles.
  - Code changes made while busy are ignored.
REQ-035 Scenario: cancel in PRESS cycle 3.
  - keypadCol goes to 1111 next cycle.
  - No press_done.
  - GAP lasts 4 cycles.
REQ-036 Scenario: reset pulse mid-PRESS.
  - keypadCol=1111 immediately without waiting for a clk edge.
  - key_ready=1 and no press_done.
REQ-037 Scenario (KEYPAD_BOUNCE_EN, BOUNCE=4): code=7, row=1110.
  - Column sequence 1110,1111,1110,1111, then a steady 1110 for the remainder of PRESS.
  - Column sequence 1110,1111,1110,1111 in GAP.
